uarc_bus_channel: RTL and testbench



---
 rtl/uarc_bus_channel.sv | 127 ++++++++++++
 tb/tb_uarc_bus_channel.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uarc_bus_channel.sv
// uarc_bus_channel: point-to-point UARC bus channel with lifecycle FSM and a send/stream FIFO
// between one sender's bus outputs and one receiver's per-bus ports.
module uarc_bus_channel #(
    parameter  int WORD_MAG   = 5,
    parameter  int DEPTH_MAG  = 2,
    localparam int WORD_WIDTH = 1 << WORD_MAG,
    localparam int DEPTH      = 1 << DEPTH_MAG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  kill,
    input  logic                  incept,
    input  logic                  send,
    input  logic                  stream,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic [WORD_WIDTH-1:0] self_permission,
    input  logic [WORD_WIDTH-1:0] self_address,
    input  logic [WORD_WIDTH-1:0] incept_permission,
    input  logic [WORD_WIDTH-1:0] incept_address,
    output logic                  kill_ack,
    output logic                  incept_ack,
    output logic                  send_ack,
    output logic                  stream_ack,
    output logic                  rx_enable,
    output logic                  rx_kill,
    output logic                  rx_incept,
    output logic                  rx_send,
    output logic                  rx_stream,
    output logic [WORD_WIDTH-1:0] rx_data,
    output logic [WORD_WIDTH-1:0] rx_self_permission,
    output logic [WORD_WIDTH-1:0] rx_self_address,
    output logic [WORD_WIDTH-1:0] rx_incept_permission,
    output logic [WORD_WIDTH-1:0] rx_incept_address,
    input  logic                  rx_kill_ack,
    input  logic                  rx_incept_ack,
    input  logic                  rx_send_ack,
    input  logic                  rx_stream_ack,
    output logic [DEPTH_MAG:0]    count
);
    typedef enum logic [1:0] {IDLE, INCEPTING, ACTIVE, KILLING} state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH:0]   mem_q [DEPTH];
    logic [DEPTH_MAG-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_MAG:0]    count_q, count_d;
    logic [WORD_WIDTH-1:0] sp_q, sa_q, ip_q, ia_q;
    logic                  full, empty, head_tag, push, pop, present;

    assign full     = count_q == (DEPTH_MAG+1)'(DEPTH);
    assign empty    = count_q == '0;
    assign head_tag = mem_q[rd_ptr_q][WORD_WIDTH];
    assign present  = state_q == ACTIVE && !empty;

    // Kill outranks incept, which outranks send/stream; stream outranks send.
    assign kill_ack   = enable & kill;
    assign incept_ack = enable & incept & ~kill & (state_q == IDLE);
    assign push       = enable & (send | stream) & ~kill & ~incept & ~full
                        & (state_q == INCEPTING || state_q == ACTIVE);
    assign send_ack   = push & ~stream;
    assign stream_ack = push & stream;
    assign pop        = present & (head_tag ? rx_stream_ack : rx_send_ack);

    always_ff @(posedge clk)
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = incept_ack ? INCEPTING : IDLE;
            INCEPTING: state_d = kill_ack ? KILLING : rx_incept_ack ? ACTIVE : INCEPTING;
            ACTIVE:    state_d = kill_ack ? KILLING : ACTIVE;
            KILLING:   state_d = rx_kill_ack ? IDLE : KILLING;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_enable = state_q != IDLE;
        rx_incept = state_q == INCEPTING;
        rx_kill   = state_q == KILLING;
        rx_send   = present & ~head_tag;
        rx_stream = present & head_tag;
        rx_data   = present ? mem_q[rd_ptr_q][WORD_WIDTH-1:0] : '0;
        count     = count_q;
    end

    // A kill accept flushes the FIFO and discards any same-cycle pop.
    always_comb begin
        wr_ptr_d = kill_ack ? '0 : wr_ptr_q + DEPTH_MAG'(push);
        rd_ptr_d = kill_ack ? '0 : rd_ptr_q + DEPTH_MAG'(pop);
        count_d  = kill_ack ? '0 : count_q + (DEPTH_MAG+1)'(push) - (DEPTH_MAG+1)'(pop);
    end

    always_ff @(posedge clk)
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end

    always_ff @(posedge clk)
        if (push) mem_q[wr_ptr_q] <= {stream, data};

    always_ff @(posedge clk)
        if (reset || (state_q == KILLING && rx_kill_ack)) begin
            sp_q <= '0;
            sa_q <= '0;
            ip_q <= '0;
            ia_q <= '0;
        end else if (incept_ack) begin
            sp_q <= self_permission;
            sa_q <= self_address;
            ip_q <= incept_permission;
            ia_q <= incept_address;
        end

    assign rx_self_permission   = sp_q;
    assign rx_self_address      = sa_q;
    assign rx_incept_permission = ip_q;
    assign rx_incept_address    = ia_q;
endmodule

// File: tb/tb_uarc_bus_channel.sv
// tb_uarc_bus_channel: directed self-checking bench for uarc_bus_channel.
module tb_uarc_bus_channel;
    logic        clk = 0, reset = 1;
    logic        enable = 0, kill = 0, incept = 0, send = 0, stream = 0;
    logic [31:0] data = 0, self_permission = 0, self_address = 0, incept_permission = 0, incept_address = 0;
    logic        kill_ack, incept_ack, send_ack, stream_ack;
    logic        rx_enable, rx_kill, rx_incept, rx_send, rx_stream;
    logic [31:0] rx_data, rx_self_permission, rx_self_address, rx_incept_permission, rx_incept_address;
    logic        rx_kill_ack = 0, rx_incept_ack = 0, rx_send_ack = 0, rx_stream_ack = 0;
    logic [2:0]  count;
    int          n_pass = 0, n_chk = 0;

    uarc_bus_channel dut (
        .clk(clk), .reset(reset), .enable(enable), .kill(kill), .incept(incept),
        .send(send), .stream(stream), .data(data), .self_permission(self_permission),
        .self_address(self_address), .incept_permission(incept_permission),
        .incept_address(incept_address), .kill_ack(kill_ack), .incept_ack(incept_ack),
        .send_ack(send_ack), .stream_ack(stream_ack), .rx_enable(rx_enable),
        .rx_kill(rx_kill), .rx_incept(rx_incept), .rx_send(rx_send), .rx_stream(rx_stream),
        .rx_data(rx_data), .rx_self_permission(rx_self_permission),
        .rx_self_address(rx_self_address), .rx_incept_permission(rx_incept_permission),
        .rx_incept_address(rx_incept_address), .rx_kill_ack(rx_kill_ack),
        .rx_incept_ack(rx_incept_ack), .rx_send_ack(rx_send_ack),
        .rx_stream_ack(rx_stream_ack), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        reset = 0;
        chk("rst_rx_enable", rx_enable, 0);
        chk("rst_count", count, 0);
        chk("rst_rx_incept", rx_incept, 0);
        chk("rst_rx_data", rx_data, 0);
        // incept
        enable = 1; incept = 1; incept_permission = 32'hA; incept_address = 32'h40;
        self_permission = 32'h5; self_address = 32'h80;
        #1;
        chk("incept_ack", incept_ack, 1);
        step();
        incept = 0;
        chk("inc_rx_incept", rx_incept, 1);
        chk("inc_rx_enable", rx_enable, 1);
        chk("inc_addr", rx_incept_address, 32'h40);
        chk("inc_perm", rx_incept_permission, 32'hA);
        chk("inc_self_addr", rx_self_address, 32'h80);
        // send during INCEPTING is queued, not presented; incept not acked
        incept = 1; #1;
        chk("inc_again_ack", incept_ack, 0);
        incept = 0; send = 1; data = 32'h11; #1;
        chk("inc_send_ack", send_ack, 1);
        step();
        send = 0;
        chk("inc_count", count, 1);
        chk("inc_no_present", rx_send, 0);
        rx_incept_ack = 1;
        step();
        rx_incept_ack = 0;
        chk("act_rx_incept", rx_incept, 0);
        chk("act_rx_send", rx_send, 1);
        chk("act_data0", rx_data, 32'h11);
        // enable qualifies requests
        enable = 0; send = 1; #1;
        chk("noen_send_ack", send_ack, 0);
        enable = 1;
        // streaming: push + pop each cycle
        data = 32'h22; rx_send_ack = 1; #1;
        chk("s22_ack", send_ack, 1);
        step();
        chk("s22_rx_send", rx_send, 1);
        chk("s22_data", rx_data, 32'h22);
        chk("s22_count", count, 1);
        send = 0; stream = 1; data = 32'h33; #1;
        chk("s33_ack", stream_ack, 1);
        step();
        stream = 0;
        chk("s33_rx_stream", rx_stream, 1);
        chk("s33_rx_send", rx_send, 0);
        chk("s33_data", rx_data, 32'h33);
        step();
        rx_send_ack = 0;
        chk("mismatch_ack_ignored", count, 1);
        rx_stream_ack = 1;
        step();
        rx_stream_ack = 0;
        chk("drain_count", count, 0);
        chk("drain_rx_stream", rx_stream, 0);
        // fill to full, receiver not acking
        send = 1;
        for (int i = 0; i < 6; i++) begin
            data = 32'h100 + i; #1;
            chk($sformatf("fill_ack%0d", i), send_ack, (i < 4) ? 1 : 0);
            step();
        end
        chk("full_count", count, 4);
        rx_send_ack = 1; #1;
        chk("full_pop_no_push", send_ack, 0);
        step();
        rx_send_ack = 0;
        chk("freed_count", count, 3);
        chk("freed_head", rx_data, 32'h101);
        #1;
        chk("freed_send_ack", send_ack, 1);
        // kill with 3 queued, concurrent send
        kill = 1; #1;
        chk("kill_ack", kill_ack, 1);
        chk("kill_blocks_send", send_ack, 0);
        step();
        kill = 0;
        chk("kill_count", count, 0);
        chk("kill_rx_kill", rx_kill, 1);
        chk("kill_rx_send", rx_send, 0);
        chk("kill_rx_enable", rx_enable, 1);
        #1;
        chk("killing_send_ack", send_ack, 0);
        kill = 1; #1;
        chk("killing_kill_ack", kill_ack, 1);
        step();
        kill = 0; send = 0;
        chk("killing_stays", rx_kill, 1);
        rx_kill_ack = 1;
        step();
        rx_kill_ack = 0;
        chk("idle_rx_enable", rx_enable, 0);
        chk("idle_rx_kill", rx_kill, 0);
        chk("idle_addr_clr", rx_incept_address, 0);
        // send while IDLE stalls
        send = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("idle_send_ack%0d", i), send_ack, 0);
            step();
        end
        send = 0;
        chk("idle_count", count, 0);
        // reset in ACTIVE with two queued words
        incept = 1; incept_address = 32'h77;
        step();
        incept = 0; rx_incept_ack = 1;
        step();
        rx_incept_ack = 0; send = 1; data = 32'hA1;
        step();
        stream = 1; data = 32'hA2; #1;
        chk("both_stream_ack", stream_ack, 1);
        chk("both_send_ack", send_ack, 0);
        step();
        send = 0; stream = 0;
        chk("pre_rst_count", count, 2);
        chk("pre_rst_head", rx_data, 32'hA1);
        reset = 1;
        step();
        reset = 0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_rx_enable", rx_enable, 0);
        chk("mid_rst_rx_send", rx_send, 0);
        chk("mid_rst_rx_data", rx_data, 0);
        chk("mid_rst_addr", rx_incept_address, 0);
        incept = 1; incept_address = 32'h99; #1;
        chk("post_rst_incept_ack", incept_ack, 1);
        step();
        incept = 0;
        chk("post_rst_rx_incept", rx_incept, 1);
        chk("post_rst_addr", rx_incept_address, 32'h99);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
